cpu_step_ctrl: RTL and testbench
================================

# cpu_step_ctrl

Run/step controller between the DE10-Lite board pins and the KLP32 core. It replaces the fixed slow core clock with a single board clock plus a one-cycle step enable, and adds selectable run modes: halt, full speed, divided rate, and debounced single-step from a push button. It also conditions the board reset into a clean synchronous core reset, counts issued steps, and optionally stops free-running execution at a PC breakpoint.

## Interface
Parameters:
- DIV_W, 32, width of the rate divisor input
- DEBOUNCE_CYCLES, 500000, cycles the synchronised button must be stable before a level change is accepted (10 ms at 50 MHz)
- CNT_W, 32, width of the step counter

Ports:
- clk  in  1  board clock; the only clock
- reset_in  in  1  asynchronous, active-low reset (board button, high when unpressed)
- i_mode  in  2  00 halt, 01 full run, 10 divided run, 11 single-step
- i_div  in  DIV_W  divided-run period in cycles; 0 is treated as 1
- i_step_btn  in  1  raw step button, active-low, asynchronous
- i_pc  in  32  current core PC
- i_break_pc  in  32  breakpoint address (STEP_BREAKPOINT_EN only)
- i_break_valid  in  1  breakpoint armed (STEP_BREAKPOINT_EN only)
- o_step_en  out  1  one-cycle core clock-enable pulse
- o_cpu_reset  out  1  active-high core reset
- o_halted  out  1  no step will issue unless the operator acts
- o_step_count  out  CNT_W  steps issued since reset

## Operation
- Reset: asserting reset_in low immediately forces o_cpu_reset=1, o_step_en=0, o_halted=1, o_step_count=0, divider=0, debounced button=1 (released), break_hit=0. Deassertion passes through a 2-flop synchroniser, so o_cpu_reset falls on the 2nd rising edge after reset_in rises. No step issues while o_cpu_reset=1.
- Button: 2-flop synchroniser, then a stability counter. The debounced level updates after DEBOUNCE_CYCLES consecutive cycles with a synchronised value differing from the current level. Any bounce restarts the count. A debounced 1->0 transition is a press event.
- Mode 00: o_step_en=0 and o_halted=1; clears break_hit.
- Mode 01: o_step_en=1 every cycle.
- Mode 10: the divider counts 0..P-1, where P=max(i_div,1). o_step_en pulses when the count equals P-1, then the count returns to 0. If i_div drops so that count>=P-1, the divider pulses and wraps on that cycle. Entering mode 10 from any other mode zeroes the divider.
- Mode 11: each press event gives exactly one o_step_en pulse; presses in other modes are discarded. o_halted=1 in this mode.
- The step is suppressed whenever o_cpu_reset=1.
- o_step_count increments on every o_step_en cycle and wraps modulo 2^CNT_W.
- o_halted=1 in modes 00 and 11, while o_cpu_reset=1, and while break_hit=1. Otherwise it is 0.
- Mode changes take effect on the next edge. No pulse that was pending under the old mode is emitted.

## Timing
- All outputs are registered. o_step_en is decided from i_mode/i_pc/divider state at edge N and is visible after edge N.
- Mode 01 gives the first pulse in the first cycle after o_cpu_reset falls.
- Press latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 output register.
- A reset mid-debounce or mid-divide discards all progress. A button held through reset does not produce a press.

## Configuration
- STEP_BREAKPOINT_EN defined:
  - In modes 01/10, a step that would issue while i_break_valid=1 and i_pc==i_break_pc is suppressed, and break_hit is set.
  - While break_hit=1, no run-mode steps issue.
  - break_hit clears on mode 00 or on a mode-11 press. The press still steps, which lets execution step past the breakpoint.
- STEP_BREAKPOINT_EN undefined: i_pc, i_break_pc and i_break_valid are ignored, and break_hit is constant 0.

## Test plan
- Hold reset_in=0 for 5 cycles in mode 01, then release. Expect o_cpu_reset=1 until the 2nd edge after release, then o_step_en=1 every cycle, and o_step_count=10 after 10 more cycles.
- Mode 10, i_div=4 for 20 cycles: expect 5 pulses spaced 4 cycles apart. Change i_div to 0: expect a pulse every cycle. Change i_div from 8 to 2 while the count is 5: expect a pulse and wrap next cycle.
- Mode 11, DEBOUNCE_CYCLES=16, press with 3 bounces of 5 cycles each, then hold 40 cycles: expect exactly one pulse, at 2+16+1 cycles after the last bounce. Release and press again: expect one more pulse, o_step_count=2.
- Mode 01, then mode 00 mid-run: expect o_step_en=0 from the next cycle and o_halted=1. A press while in mode 00 gives no pulse.
- STEP_BREAKPOINT_EN, mode 01, i_break_pc=0x40, i_pc ramping by 4: expect no pulse when i_pc=0x40 and o_halted=1. Switch to mode 11 and press: expect one pulse, break_hit cleared. Return to mode 01: expect a pulse every cycle.
- Set o_step_count=2^CNT_W-1 (CNT_W=4, 15 steps), then issue one more step: expect o_step_count=0.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl - run/step controller between the DE10-Lite board and the KLP32 core.
// Turns the single board clock into a one-cycle core step enable with four run modes
// (halt, full speed, divided rate, debounced single-step), conditions the board reset
// into a synchronous core reset and counts issued steps.
// Optional feature: define STEP_BREAKPOINT_EN to stop free-running execution when the
// core PC reaches an armed breakpoint address.
module cpu_step_ctrl #(
    parameter int DIV_W           = 32,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_step_btn,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_break_pc,
    input  logic             i_break_valid,
    output logic             o_step_en,
    output logic             o_cpu_reset,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_step_count
);

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_DIV  = 2'b10,
        MODE_STEP = 2'b11
    } mode_e;

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Effective divided-run period: a programmed 0 behaves like 1.
    function automatic logic [DIV_W-1:0] eff_period(input logic [DIV_W-1:0] div);
        eff_period = (div == DIV_W'(0)) ? DIV_W'(1) : div;
    endfunction

    // Reset conditioning
    logic rst_sync_r;
    logic cpu_reset_r;
    logic reset_next_s;

    // Button path
    logic            btn_meta_r;
    logic            btn_sync_r;
    logic [DB_W-1:0] db_cnt_r;
    logic            btn_db_r;
    logic            btn_db_prev_r;
    logic            btn_armed_r;
    logic            press_s;

    // Step generation
    mode_e            mode_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_next_s;
    logic [DIV_W-1:0] period_s;
    logic             div_hit_s;
    logic             step_next_s;
    logic             halted_next_s;
    logic             break_hit_r;
    logic             break_next_s;
    logic             bp_match_s;
    logic             run_block_s;
    logic             step_en_r;
    logic             halted_r;
    logic [CNT_W-1:0] step_count_r;

    assign mode_s = mode_e'(i_mode);

    // Two-flop release synchroniser; cpu_reset_r is the second stage so the core
    // reset drops on the second rising edge after reset_in goes high.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            rst_sync_r  <= 1'b0;
            cpu_reset_r <= 1'b1;
        end else begin
            rst_sync_r  <= 1'b1;
            cpu_reset_r <= ~rst_sync_r;
        end
    end

    // Value o_cpu_reset takes at this edge; steps are gated on it so a step never
    // coincides with an asserted core reset and the first run step follows at once.
    assign reset_next_s = ~rst_sync_r;

    // Two-flop synchroniser for the asynchronous, active-low step button.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            btn_meta_r <= 1'b1;
            btn_sync_r <= 1'b1;
        end else begin
            btn_meta_r <= i_step_btn;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Stability counter: accept a new level only after DEBOUNCE_CYCLES consecutive
    // differing samples; any sample equal to the current level restarts the count.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            db_cnt_r      <= DB_W'(0);
            btn_db_r      <= 1'b1;
            btn_db_prev_r <= 1'b1;
        end else begin
            btn_db_prev_r <= btn_db_r;
            if (btn_sync_r != btn_db_r) begin
                if (db_cnt_r == DB_LAST) begin
                    btn_db_r <= btn_sync_r;
                    db_cnt_r <= DB_W'(0);
                end else begin
                    db_cnt_r <= db_cnt_r + DB_W'(1);
                end
            end else begin
                db_cnt_r <= DB_W'(0);
            end
        end
    end

    // Presses only count once a genuinely released button has been seen after reset,
    // so a button held down through reset cannot step the core on its own.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            btn_armed_r <= 1'b0;
        end else begin
            btn_armed_r <= btn_armed_r | (btn_sync_r & ~cpu_reset_r);
        end
    end

    assign press_s = btn_armed_r & btn_db_prev_r & ~btn_db_r;

`ifdef STEP_BREAKPOINT_EN
    assign bp_match_s  = i_break_valid & (i_pc == i_break_pc);
    assign run_block_s = break_hit_r | bp_match_s;
`else
    // Breakpoint inputs are not used in this build.
    logic unused_bp_s;
    assign unused_bp_s = ^{i_pc, i_break_pc, i_break_valid};
    assign bp_match_s  = 1'b0;
    assign run_block_s = 1'b0;
`endif

    assign period_s  = eff_period(i_div);
    assign div_hit_s = (div_r >= (period_s - DIV_W'(1)));

    // Next-step decision: mode selects the step source; the divider is held at 0
    // outside divided mode so entering it always starts a fresh period.
    always_comb begin
        step_next_s  = 1'b0;
        div_next_s   = DIV_W'(0);
        break_next_s = break_hit_r;
        if (reset_next_s) begin
            step_next_s  = 1'b0;
            break_next_s = 1'b0;
        end else begin
            case (mode_s)
                MODE_HALT: begin
                    break_next_s = 1'b0;
                end
                MODE_RUN: begin
                    step_next_s  = ~run_block_s;
                    break_next_s = break_hit_r | bp_match_s;
                end
                MODE_DIV: begin
                    if (div_hit_s) begin
                        div_next_s   = DIV_W'(0);
                        step_next_s  = ~run_block_s;
                        break_next_s = break_hit_r | bp_match_s;
                    end else begin
                        div_next_s   = div_r + DIV_W'(1);
                    end
                end
                MODE_STEP: begin
                    if (press_s) begin
                        // A press steps past a breakpoint and re-enables running.
                        step_next_s  = 1'b1;
                        break_next_s = 1'b0;
                    end else begin
                        step_next_s  = 1'b0;
                    end
                end
                default: begin
                    step_next_s  = 1'b0;
                end
            endcase
        end
        halted_next_s = (mode_s == MODE_HALT) | (mode_s == MODE_STEP) |
                        reset_next_s | break_next_s;
    end

    // Output, divider, breakpoint and step-count registers.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            step_en_r    <= 1'b0;
            halted_r     <= 1'b1;
            div_r        <= DIV_W'(0);
            break_hit_r  <= 1'b0;
            step_count_r <= CNT_W'(0);
        end else begin
            step_en_r    <= step_next_s;
            halted_r     <= halted_next_s;
            div_r        <= div_next_s;
            break_hit_r  <= break_next_s;
            step_count_r <= step_count_r + CNT_W'(step_next_s);
        end
    end

    assign o_step_en    = step_en_r;
    assign o_cpu_reset  = cpu_reset_r;
    assign o_halted     = halted_r;
    assign o_step_count = step_count_r;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed testbench for cpu_step_ctrl (DEBOUNCE_CYCLES=16, CNT_W=4).
module tb_cpu_step_ctrl;

    logic        clk;
    logic        reset_in;
    logic [1:0]  i_mode;
    logic [31:0] i_div;
    logic        i_step_btn;
    logic [31:0] i_pc;
    logic [31:0] i_break_pc;
    logic        i_break_valid;
    logic        o_step_en;
    logic        o_cpu_reset;
    logic        o_halted;
    logic [3:0]  o_step_count;

    int         vectors;
    int         miscompares;
    logic [3:0] exp_cnt;

    cpu_step_ctrl #(
        .DIV_W(32),
        .DEBOUNCE_CYCLES(16),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset_in(reset_in),
        .i_mode(i_mode),
        .i_div(i_div),
        .i_step_btn(i_step_btn),
        .i_pc(i_pc),
        .i_break_pc(i_break_pc),
        .i_break_valid(i_break_valid),
        .o_step_en(o_step_en),
        .o_cpu_reset(o_cpu_reset),
        .o_halted(o_halted),
        .o_step_count(o_step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_in = 1'b0; i_mode = 2'b01; i_div = 32'd0; i_step_btn = 1'b1;
        i_pc = 32'h0; i_break_pc = 32'h40; i_break_valid = 1'b0;
        repeat (5) tick();
        vectors++; if (o_cpu_reset !== 1'b1) begin miscompares++; $display("FAIL rst_cpu_reset got %b exp 1", o_cpu_reset); end
        vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL rst_step_en got %b exp 0", o_step_en); end
        vectors++; if (o_halted !== 1'b1) begin miscompares++; $display("FAIL rst_halted got %b exp 1", o_halted); end
        vectors++; if (o_step_count !== 4'd0) begin miscompares++; $display("FAIL rst_count got %0d exp 0", o_step_count); end
        reset_in = 1'b1;
        tick();
        vectors++; if (o_cpu_reset !== 1'b1) begin miscompares++; $display("FAIL rel1_cpu_reset got %b exp 1", o_cpu_reset); end
        vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL rel1_step_en got %b exp 0", o_step_en); end
        tick();
        vectors++; if (o_cpu_reset !== 1'b0) begin miscompares++; $display("FAIL rel2_cpu_reset got %b exp 0", o_cpu_reset); end
        vectors++; if (o_step_en !== 1'b1) begin miscompares++; $display("FAIL rel2_step_en got %b exp 1", o_step_en); end
        vectors++; if (o_halted !== 1'b0) begin miscompares++; $display("FAIL rel2_halted got %b exp 0", o_halted); end
        exp_cnt = 4'd1;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_cnt = exp_cnt + 4'd1;
            vectors++; if (o_step_en !== 1'b1) begin miscompares++; $display("FAIL run_step_en cycle %0d got %b exp 1", i, o_step_en); end
        end
        vectors++; if (o_step_count !== 4'd10) begin miscompares++; $display("FAIL run_count got %0d exp 10", o_step_count); end
    endtask

    task automatic test_divided();
        logic exp;
        i_mode = 2'b10; i_div = 32'd4;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp = ((i % 4) == 0);
            if (exp) exp_cnt = exp_cnt + 4'd1;
            vectors++; if (o_step_en !== exp) begin miscompares++; $display("FAIL div4_step cycle %0d got %b exp %b", i, o_step_en, exp); end
        end
        vectors++; if (o_halted !== 1'b0) begin miscompares++; $display("FAIL div4_halted got %b exp 0", o_halted); end
        vectors++; if (o_step_count !== exp_cnt) begin miscompares++; $display("FAIL div4_count got %0d exp %0d", o_step_count, exp_cnt); end
        i_div = 32'd0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_cnt = exp_cnt + 4'd1;
            vectors++; if (o_step_en !== 1'b1) begin miscompares++; $display("FAIL div0_step cycle %0d got %b exp 1", i, o_step_en); end
        end
        i_mode = 2'b00;
        tick();
        vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL div_halt_step got %b exp 0", o_step_en); end
        vectors++; if (o_halted !== 1'b1) begin miscompares++; $display("FAIL div_halt_halted got %b exp 1", o_halted); end
        i_mode = 2'b10; i_div = 32'd8;
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL div8_step cycle %0d got %b exp 0", i, o_step_en); end
        end
        i_div = 32'd2;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        vectors++; if (o_step_en !== 1'b1) begin miscompares++; $display("FAIL div_drop_wrap got %b exp 1", o_step_en); end
        tick();
        vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL div2_gap got %b exp 0", o_step_en); end
        tick();
        exp_cnt = exp_cnt + 4'd1;
        vectors++; if (o_step_en !== 1'b1) begin miscompares++; $display("FAIL div2_pulse got %b exp 1", o_step_en); end
        vectors++; if (o_step_count !== exp_cnt) begin miscompares++; $display("FAIL div_count got %0d exp %0d", o_step_count, exp_cnt); end
    endtask

    task automatic test_halt();
        i_mode = 2'b01;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        vectors++; if (o_step_en !== 1'b1) begin miscompares++; $display("FAIL halt_pre_step got %b exp 1", o_step_en); end
        i_mode = 2'b00;
        tick();
        vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL halt_step got %b exp 0", o_step_en); end
        vectors++; if (o_halted !== 1'b1) begin miscompares++; $display("FAIL halt_halted got %b exp 1", o_halted); end
        i_step_btn = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL halt_press cycle %0d got %b exp 0", i, o_step_en); end
        end
        i_step_btn = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL halt_release cycle %0d got %b exp 0", i, o_step_en); end
        end
        vectors++; if (o_step_count !== exp_cnt) begin miscompares++; $display("FAIL halt_count got %0d exp %0d", o_step_count, exp_cnt); end
    endtask

    task automatic press_and_release(input string tag);
        logic exp;
        i_step_btn = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            exp = (i == 19);
            if (exp) exp_cnt = exp_cnt + 4'd1;
            vectors++; if (o_step_en !== exp) begin miscompares++; $display("FAIL %s_press cycle %0d got %b exp %b", tag, i, o_step_en, exp); end
        end
        i_step_btn = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL %s_release cycle %0d got %b exp 0", tag, i, o_step_en); end
        end
    endtask

    task automatic test_single_step();
        logic exp;
        i_mode = 2'b11;
        tick();
        vectors++; if (o_halted !== 1'b1) begin miscompares++; $display("FAIL step_halted got %b exp 1", o_halted); end
        for (int b = 0; b < 3; b++) begin
            i_step_btn = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL bounce_low %0d/%0d got %b exp 0", b, i, o_step_en); end
            end
            i_step_btn = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL bounce_high %0d/%0d got %b exp 0", b, i, o_step_en); end
            end
        end
        i_step_btn = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            exp = (i == 19);
            if (exp) exp_cnt = exp_cnt + 4'd1;
            vectors++; if (o_step_en !== exp) begin miscompares++; $display("FAIL hold_press cycle %0d got %b exp %b", i, o_step_en, exp); end
        end
        i_step_btn = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL hold_release cycle %0d got %b exp 0", i, o_step_en); end
        end
        press_and_release("second");
        vectors++; if (o_step_count !== exp_cnt) begin miscompares++; $display("FAIL step_count got %0d exp %0d", o_step_count, exp_cnt); end
    endtask

    task automatic test_breakpoint();
        logic exp_step;
        logic exp_halt;
        i_break_pc = 32'h40; i_break_valid = 1'b1; i_mode = 2'b01;
        for (int k = 0; k < 6; k++) begin
            i_pc = 32'h30 + 32'(4 * k);
`ifdef STEP_BREAKPOINT_EN
            exp_step = (k < 4);
            exp_halt = (k >= 4);
`else
            exp_step = 1'b1;
            exp_halt = 1'b0;
`endif
            tick();
            if (exp_step) exp_cnt = exp_cnt + 4'd1;
            vectors++; if (o_step_en !== exp_step) begin miscompares++; $display("FAIL bp_step pc %h got %b exp %b", i_pc, o_step_en, exp_step); end
            vectors++; if (o_halted !== exp_halt) begin miscompares++; $display("FAIL bp_halted pc %h got %b exp %b", i_pc, o_halted, exp_halt); end
        end
`ifdef STEP_BREAKPOINT_EN
        i_mode = 2'b11;
        tick();
        vectors++; if (o_halted !== 1'b1) begin miscompares++; $display("FAIL bp_step_mode_halted got %b exp 1", o_halted); end
        press_and_release("bp");
        i_mode = 2'b01; i_pc = 32'h48;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_cnt = exp_cnt + 4'd1;
            vectors++; if (o_step_en !== 1'b1) begin miscompares++; $display("FAIL bp_resume_step cycle %0d got %b exp 1", i, o_step_en); end
            vectors++; if (o_halted !== 1'b0) begin miscompares++; $display("FAIL bp_resume_halted cycle %0d got %b exp 0", i, o_halted); end
        end
`endif
        i_break_valid = 1'b0;
        vectors++; if (o_step_count !== exp_cnt) begin miscompares++; $display("FAIL bp_count got %0d exp %0d", o_step_count, exp_cnt); end
    endtask

    task automatic test_btn_through_reset();
        i_step_btn = 1'b0; i_mode = 2'b11; reset_in = 1'b0;
        repeat (3) tick();
        exp_cnt = 4'd0;
        vectors++; if (o_step_count !== 4'd0) begin miscompares++; $display("FAIL held_rst_count got %0d exp 0", o_step_count); end
        reset_in = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL held_no_press cycle %0d got %b exp 0", i, o_step_en); end
        end
        i_step_btn = 1'b1;
        repeat (25) tick();
        press_and_release("after_held");
        vectors++; if (o_step_count !== 4'd1) begin miscompares++; $display("FAIL held_count got %0d exp 1", o_step_count); end
    endtask

    task automatic test_wrap();
        i_mode = 2'b01; i_step_btn = 1'b1; reset_in = 1'b0;
        repeat (2) tick();
        reset_in = 1'b1;
        repeat (2) tick();
        repeat (14) tick();
        vectors++; if (o_step_count !== 4'd15) begin miscompares++; $display("FAIL wrap_max got %0d exp 15", o_step_count); end
        tick();
        vectors++; if (o_step_count !== 4'd0) begin miscompares++; $display("FAIL wrap_zero got %0d exp 0", o_step_count); end
        vectors++; if (o_step_en !== 1'b1) begin miscompares++; $display("FAIL wrap_step got %b exp 1", o_step_en); end
        // Asynchronous reset between clock edges must act immediately.
        #2;
        reset_in = 1'b0;
        #1;
        vectors++; if (o_step_en !== 1'b0) begin miscompares++; $display("FAIL async_step got %b exp 0", o_step_en); end
        vectors++; if (o_cpu_reset !== 1'b1) begin miscompares++; $display("FAIL async_cpu_reset got %b exp 1", o_cpu_reset); end
        vectors++; if (o_halted !== 1'b1) begin miscompares++; $display("FAIL async_halted got %b exp 1", o_halted); end
        vectors++; if (o_step_count !== 4'd0) begin miscompares++; $display("FAIL async_count got %0d exp 0", o_step_count); end
        tick();
        reset_in = 1'b1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_cnt = 4'd0;
        test_reset();
        test_divided();
        test_halt();
        test_single_step();
        test_breakpoint();
        test_btn_through_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
